key_debounce: RTL and testbench

Front-end key conditioner for the clock design. Synchronises one raw, bouncing, active-low push-button input to `clk` and filters it with a debounce state machine. Emits a single-cycle, active-high press pulse that feeds the mode counter's `key_in` directly. One instance is used per physical key. An optional long-press auto-repeat output drives fast time-setting.

---
 rtl/shizhong_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/key_debounce.sv | 153 +++++++++++++++
 tb/tb_key_debounce.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shizhong_pkg.sv
// Shared types and default timing constants for the clock front-end stages.
// Holds the key conditioner state enum and a small helper for counter sizing.
package shizhong_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } key_state_t;

  // Defaults assume a 50 MHz clk.
  localparam int KEY_DEBOUNCE_DEF = 1_000_000;
  localparam int KEY_LONG_DEF     = 50_000_000;
  localparam int KEY_REPEAT_DEF   = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value
// so idle-high and idle-low signals both come out of reset in their idle state.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {WIDTH{RST_VAL}};
      q    <= {WIDTH{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low push-button and emits a one-cycle press pulse.
// Optional long-press / auto-repeat pulses are built when KEY_LONG_EN is defined.
//
// state      | meaning
// IDLE       | key released and stable
// PRESS_FILT | key seen low, waiting for DEBOUNCE_CYCLES of stability
// PRESSED    | key accepted as held; long-press timer runs here
// REL_FILT   | key seen high, waiting for DEBOUNCE_CYCLES of stability
module key_debounce
  import shizhong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = KEY_LONG_DEF,
  parameter int REPEAT_CYCLES   = KEY_REPEAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_pulse,
  output logic key_level,
  output logic key_long
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic             ks;
  key_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_n),
    .q     (ks)
  );

  // Saturate rather than wrap so a stuck state can never fake a terminal count.
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

`ifdef KEY_LONG_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  logic long_rep, long_rep_next, long_fire, key_long_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
`ifdef KEY_LONG_EN
    long_fire  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!ks) begin
          state_next = PRESS_FILT;
          cnt_next   = '0;
        end
      end
      PRESS_FILT: begin
        if (ks) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (ks) begin
          state_next = REL_FILT;
          cnt_next   = '0;
        end else begin
`ifdef KEY_LONG_EN
          // First pulse waits LONG_CYCLES, later ones every REPEAT_CYCLES.
          if ((!long_rep && cnt == LONG_LAST) || (long_rep && cnt == REP_LAST)) begin
            long_fire = 1'b1;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt_inc;
          end
`endif
        end
      end
      REL_FILT: begin
        if (!ks) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pulse <= 1'b0;
      key_level <= 1'b0;
    end else begin
      key_pulse <= (state == PRESS_FILT) && (state_next == PRESSED);
      key_level <= (state_next == PRESSED) || (state_next == REL_FILT);
    end
  end

`ifdef KEY_LONG_EN
  // Any path into PRESSED from elsewhere restarts the full long-press wait.
  always_comb begin
    long_rep_next = 1'b0;
    if (state == PRESSED && state_next == PRESSED) begin
      long_rep_next = long_rep | long_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_rep   <= 1'b0;
      key_long_q <= 1'b0;
    end else begin
      long_rep   <= long_rep_next;
      key_long_q <= long_fire;
    end
  end

  assign key_long = key_long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random key
// traffic, all compared cycle by cycle against a run-length reference model.
module tb_key_debounce;

  localparam int D = 8;
  localparam int L = 32;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic key_n;
  logic key_pulse, key_level, key_long;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int long_cnt = 0;
  int overlap_cnt = 0;

  // Reference model: a delay line for the two sync stages, then level flips
  // once the opposite key value has been observed D+1 times in a row.
  bit m_s1, m_s2, m_level, m_pulse, m_long;
  int m_run, m_hold;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .key_pulse (key_pulse),
    .key_level (key_level),
    .key_long  (key_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d t=%0t", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1;
    m_s2 = 1'b1;
    m_level = 1'b0;
    m_pulse = 1'b0;
    m_long = 1'b0;
    m_run = 0;
    m_hold = -1;
  endtask

  task automatic model_edge(input bit raw);
    bit pressed_obs;
    pressed_obs = (m_s2 == 1'b0);
    m_s2 = m_s1;
    m_s1 = raw;
    m_pulse = 1'b0;
    m_long = 1'b0;
    if (m_level) begin
      if (!pressed_obs) begin
        m_run++;
        m_hold = -1;
        if (m_run == D + 1) begin
          m_level = 1'b0;
          m_run = 0;
        end
      end else begin
        m_run = 0;
        m_hold++;
`ifdef KEY_LONG_EN
        if (m_hold >= L && ((m_hold - L) % R) == 0) m_long = 1'b1;
`endif
      end
    end else begin
      if (pressed_obs) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = 1'b1;
          m_run = 0;
          m_pulse = 1'b1;
          m_hold = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Drive key_n away from the edge, advance one clock, then compare.
  task automatic tick(input logic kv);
    key_n = kv;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(kv);
    #1;
    check("level", {31'd0, key_level}, {31'd0, m_level});
    check("pulse", {31'd0, key_pulse}, {31'd0, m_pulse});
    check("long", {31'd0, key_long}, {31'd0, m_long});
    if (key_pulse) pulse_cnt++;
    if (key_long) long_cnt++;
    if (key_pulse && key_long) overlap_cnt++;
  endtask

  initial begin
    int first_at;
    int val;
    int len;
    int exp_long;

    rst_n = 1'b0;
    key_n = 1'b0;
    model_reset();
    #1;
    check("rst_level", {31'd0, key_level}, 32'd0);
    check("rst_pulse", {31'd0, key_pulse}, 32'd0);
    check("rst_long", {31'd0, key_long}, 32'd0);
    repeat (3) tick(1'b0);

    // Key held low through reset release: one pulse 3+D edges later.
    rst_n = 1'b1;
    cyc = 0;
    pulse_cnt = 0;
    first_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0);
      if (key_pulse && first_at < 0) first_at = i;
    end
    check("rst_rel_pulse_at", first_at, 3 + D);
    check("rst_rel_pulse_cnt", pulse_cnt, 1);
    repeat (15) tick(1'b1);
    check("rst_rel_released", {31'd0, key_level}, 32'd0);

    // Clean press, then clean release.
    pulse_cnt = 0;
    first_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0);
      if (key_pulse && first_at < 0) first_at = i;
    end
    check("press_lat", first_at, 3 + D);
    check("press_cnt", pulse_cnt, 1);
    first_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1);
      if (!key_level && first_at < 0) first_at = i;
    end
    check("release_lat", first_at, 3 + D);
    check("release_no_pulse", pulse_cnt, 1);

    // Bounce: 3 low / 2 high, never long enough to qualify.
    pulse_cnt = 0;
    first_at = 0;
    for (int i = 0; i < 30; i++) begin
      tick((i % 5) < 3 ? 1'b0 : 1'b1);
      if (key_level) first_at++;
    end
    repeat (15) begin
      tick(1'b1);
      if (key_level) first_at++;
    end
    check("bounce_pulse", pulse_cnt, 0);
    check("bounce_level_cycles", first_at, 0);

    // Release bounce while pressed.
    pulse_cnt = 0;
    repeat (15) tick(1'b0);
    first_at = 0;
    repeat (5) begin
      tick(1'b1);
      if (!key_level) first_at++;
    end
    repeat (20) begin
      tick(1'b0);
      if (!key_level) first_at++;
    end
    check("relbounce_level_drop", first_at, 0);
    check("relbounce_pulse", pulse_cnt, 1);
    repeat (15) tick(1'b1);

    // Long press: held 60 cycles after PRESSED.
`ifdef KEY_LONG_EN
    exp_long = 4;
`else
    exp_long = 0;
`endif
    pulse_cnt = 0;
    long_cnt = 0;
    repeat (3 + D + 60) tick(1'b0);
    check("long_cnt", long_cnt, exp_long);
    check("long_pulse_cnt", pulse_cnt, 1);
    repeat (15) tick(1'b1);

    // Reset in the middle of a held press: outputs drop at once.
    repeat (15) tick(1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_level", {31'd0, key_level}, 32'd0);
    check("midrst_pulse", {31'd0, key_pulse}, 32'd0);
    check("midrst_long", {31'd0, key_long}, 32'd0);
    model_reset();
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    pulse_cnt = 0;
    first_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0);
      if (key_pulse && first_at < 0) first_at = i;
    end
    check("midrst_requal_at", first_at, 3 + D);
    repeat (15) tick(1'b1);

    // Random traffic: mixes sub-threshold glitches with long stable holds.
    repeat (120) begin
      val = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) len = $urandom_range(1, D);
      else len = $urandom_range(D, 80);
      repeat (len) tick(val[0]);
    end
    repeat (20) tick(1'b1);

    check("pulse_long_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
